// File: rtl/genius_pkg.sv
// Shared definitions for the Genius colour-sequence player.
// Colour codes match the select encoding of the downstream 4:1 mux.
package genius_pkg;

    typedef logic [1:0] colour_t;

    localparam colour_t C_GREEN  = 2'b00;
    localparam colour_t C_RED    = 2'b01;
    localparam colour_t C_YELLOW = 2'b10;
    localparam colour_t C_BLUE   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int DEF_ON_CYC  = 4;
    localparam int DEF_OFF_CYC = 2;

endpackage

// File: rtl/genius_seq_mem.sv
// Colour sequence store: DEPTH x 2-bit register file.
// Synchronous write, asynchronous read; contents survive reset.
module genius_seq_mem
    import genius_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  colour_t       wr_data,
    input  logic [AW-1:0] rd_addr,
    output colour_t       rd_data
);

    colour_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/genius_seq_player.sv
// Plays the first LEN stored colours: SHOW high ON_CYC cycles,
// then dark OFF_CYC cycles per step; DONE pulses after the last one.
module genius_seq_player
    import genius_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int ON_CYC  = DEF_ON_CYC,
    parameter int OFF_CYC = DEF_OFF_CYC,
    parameter int CW      = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [1:0]    WR_DATA,
    input  logic [AW:0]   LEN,
    input  logic          START,
    output logic [1:0]    SEL,
    output logic          SHOW,
    output logic          BUSY,
    output logic          DONE
);

    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] ON_LD   = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LD  = CW'(OFF_CYC - 1);

    state_t        state;
    logic [AW:0]   step;
    logic [AW:0]   step_nx;
    logic [AW:0]   len_q;
    logic [CW-1:0] timer;
    logic [AW-1:0] rd_addr;
    colour_t       rd_data;

    assign step_nx = step + 1'b1;
    // One read port: step 0 when launching, otherwise the next step.
    assign rd_addr = (state == IDLE) ? '0 : step_nx[AW-1:0];

    genius_seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (WR_EN),
        .wr_addr (WR_ADDR),
        .wr_data (WR_DATA),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            SEL   <= C_GREEN;
            SHOW  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            step  <= '0;
            len_q <= '0;
            timer <= '0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The DONE cycle itself does not accept a new START.
                    if (START && !DONE) begin
                        if (LEN == '0) begin
                            state <= FIN;
                        end else begin
                            len_q <= (LEN > LEN_MAX) ? LEN_MAX : LEN;
                            step  <= '0;
                            SEL   <= rd_data;
                            SHOW  <= 1'b1;
                            BUSY  <= 1'b1;
                            timer <= ON_LD;
                            state <= ON;
                        end
                    end
                end
                ON: begin
                    if (timer == '0) begin
                        SHOW  <= 1'b0;
                        timer <= OFF_LD;
                        state <= OFF;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                OFF: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (step_nx < len_q) begin
                        step  <= step_nx;
                        SEL   <= rd_data;
                        SHOW  <= 1'b1;
                        timer <= ON_LD;
                        state <= ON;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_genius_seq_player.sv
// Bench for genius_seq_player: timeline model checked every cycle,
// plus directed literal checks on sequences, durations and DONE timing.
module tb_genius_seq_player;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;

    logic       clk;
    logic       RST;
    logic       WR_EN;
    logic [3:0] WR_ADDR;
    logic [1:0] WR_DATA;
    logic [4:0] LEN;
    logic       START;
    logic [1:0] SEL;
    logic       SHOW;
    logic       BUSY;
    logic       DONE;

    genius_seq_player #(
        .DEPTH   (16),
        .AW      (4),
        .ON_CYC  (ON),
        .OFF_CYC (OFF),
        .CW      (16)
    ) dut (
        .CLK     (clk),
        .RST     (RST),
        .WR_EN   (WR_EN),
        .WR_ADDR (WR_ADDR),
        .WR_DATA (WR_DATA),
        .LEN     (LEN),
        .START   (START),
        .SEL     (SEL),
        .SHOW    (SHOW),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Timeline model: k counts cycles since launch; step = k/P, lit while k%P < ON.
    logic [1:0] mmem [16];
    int   k, m_len;
    bit   playing, fin_pend;
    logic [1:0] m_sel;
    logic m_show, m_busy, m_done;

    always @(posedge clk) begin
        bit was_done;
        was_done = m_done;
        m_done = 1'b0;
        if (RST) begin
            playing  = 1'b0;
            fin_pend = 1'b0;
            m_sel    = 2'd0;
            m_show   = 1'b0;
            m_busy   = 1'b0;
        end else if (playing) begin
            k++;
            if (k == m_len * P) begin
                playing  = 1'b0;
                m_busy   = 1'b0;
                m_show   = 1'b0;
                fin_pend = 1'b1;
            end else begin
                m_show = ((k % P) < ON);
                if (k % P == 0) m_sel = mmem[k / P];
            end
        end else if (fin_pend) begin
            fin_pend = 1'b0;
            m_done   = 1'b1;
        end else if (START && !was_done) begin
            if (LEN == 0) begin
                fin_pend = 1'b1;
            end else begin
                m_len   = (LEN > 16) ? 16 : int'(LEN);
                playing = 1'b1;
                k       = 0;
                m_busy  = 1'b1;
                m_show  = 1'b1;
                m_sel   = mmem[0];
            end
        end
        if (WR_EN) mmem[WR_ADDR] = WR_DATA;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if ({SEL, SHOW, BUSY, DONE} === {m_sel, m_show, m_busy, m_done})
                n_pass++;
            else
                $display("FAIL model cyc=%0d sel/show/busy/done got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, SEL, SHOW, BUSY, DONE, m_sel, m_show, m_busy, m_done);
        end
    end

    // Observed statistics for the directed checks.
    int   busy_cnt, show_cnt, done_cnt, done_cyc, busy_fall, busy_rise;
    int   sel_log [$];
    logic prev_show = 1'b0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (SHOW && !prev_show) sel_log.push_back(int'(SEL));
            if (SHOW) show_cnt++;
            if (BUSY) busy_cnt++;
            if (BUSY && !prev_busy) busy_rise = cyc;
            if (!BUSY && prev_busy) busy_fall = cyc;
            if (DONE) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_show = SHOW;
        prev_busy = BUSY;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got %0d want %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        sel_log.delete();
        busy_cnt = 0;
        show_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        busy_fall = -1;
        busy_rise = -1;
    endtask

    task automatic write(input int a, input int d);
        WR_EN   = 1'b1;
        WR_ADDR = 4'(a);
        WR_DATA = 2'(d);
        tick();
        WR_EN   = 1'b0;
    endtask

    task automatic play(input int len, output int c);
        LEN   = 5'(len);
        START = 1'b1;
        c     = cyc;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            tick();
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    int c0, d1;
    int exp_seq [4] = '{3, 1, 0, 2};

    initial begin
        RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        LEN = '0;   START = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        RST = 1'b0;
        @(negedge clk);
        check("rst_sel", int'(SEL), 0);
        check("rst_show", int'(SHOW), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        tick();

        for (int i = 0; i < 4; i++) write(i, exp_seq[i]);
        for (int i = 4; i < 16; i++) write(i, (i * 3 + 1) % 4);

        // Basic four-step playback
        clr();
        play(4, c0);
        wait_done(1, 60);
        check("p4_steps", sel_log.size(), 4);
        for (int i = 0; i < 4 && i < sel_log.size(); i++)
            check($sformatf("p4_sel%0d", i), sel_log[i], exp_seq[i]);
        check("p4_busy", busy_cnt, 24);
        check("p4_show", show_cnt, 16);
        check("p4_done_n", done_cnt, 1);
        check("p4_done_at", done_cyc, busy_fall + 1);
        check("p4_first_show", busy_rise, c0 + 1);
        tick();

        // Zero length
        clr();
        play(0, c0);
        wait_done(1, 10);
        repeat (3) tick();
        check("l0_done_at", done_cyc, c0 + 2);
        check("l0_done_n", done_cnt, 1);
        check("l0_busy", busy_cnt, 0);
        check("l0_show", show_cnt, 0);

        // Length clamped to DEPTH
        clr();
        play(20, c0);
        wait_done(1, 200);
        check("l20_steps", sel_log.size(), 16);
        check("l20_busy", busy_cnt, 96);
        if (sel_log.size() > 0)
            check("l20_last", sel_log[sel_log.size() - 1], 2);
        tick();

        // STARTs during playback are ignored
        clr();
        play(4, c0);
        repeat (7) tick();
        START = 1'b1; tick(); START = 1'b0;
        repeat (11) tick();
        START = 1'b1; tick(); START = 1'b0;
        wait_done(1, 60);
        repeat (4) tick();
        check("ign_done_n", done_cnt, 1);
        check("ign_steps", sel_log.size(), 4);
        check("ign_busy", busy_cnt, 24);

        // START held high restarts after DONE
        clr();
        LEN = 5'd2;
        START = 1'b1;
        wait_done(1, 40);
        d1 = done_cyc;
        for (int i = 0; i < 5 && busy_rise <= d1; i++) tick();
        START = 1'b0;
        check("hold_restart", busy_rise, d1 + 2);
        wait_done(2, 40);
        tick();

        // Reset in OFF of step 2
        clr();
        play(4, c0);
        repeat (16) tick();
        RST = 1'b1; tick(); RST = 1'b0;
        @(negedge clk);
        check("abort_sel", int'(SEL), 0);
        check("abort_show", int'(SHOW), 0);
        check("abort_busy", int'(BUSY), 0);
        repeat (8) tick();
        check("abort_no_done", done_cnt, 0);
        clr();
        play(4, c0);
        wait_done(1, 60);
        check("replay_steps", sel_log.size(), 4);
        for (int i = 0; i < 4 && i < sel_log.size(); i++)
            check($sformatf("replay_sel%0d", i), sel_log[i], exp_seq[i]);
        tick();

        // Writes while step 1 is shown
        clr();
        play(4, c0);
        repeat (7) tick();
        write(3, 1);
        write(1, 3);
        wait_done(1, 60);
        check("wr_steps", sel_log.size(), 4);
        if (sel_log.size() == 4) begin
            check("wr_step1", sel_log[1], 1);
            check("wr_step3", sel_log[3], 1);
        end
        tick(); tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
